pattern_checker: RTL and testbench

Self-checking receiver for the bit-pattern stimulus that the team's benches apply to a device under test. It observes one response bit and holds each pattern bit for a fixed dwell period. It samples that bit at the centre of each dwell, compares it against a parameterised expected sequence, counts mismatches, and reports pass/fail with a done pulse. This lets a bench drive a DUT and have the verdict produced in hardware instead of by eye.

---
 rtl/pattern_checker_pkg.sv | 19 +
 rtl/pattern_checker_dwell.sv | 39 +++
 rtl/pattern_checker.sv | 127 ++++++++++++
 tb/tb_pattern_checker.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/pattern_checker_pkg.sv
// Shared definitions for the pattern checker and its stimulus generator.
// Holds the FSM encoding, the default run geometry and a width helper.
package pattern_checker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int unsigned DEF_DWELL   = 20;
  localparam int unsigned DEF_PAT_LEN = 4;

  // Index width that stays at least one bit for single-entry ranges
  function automatic int unsigned w_min1(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pattern_checker_dwell.sv
// Dwell counter: walks 0..DWELL-1 and flags the sample and last cycles.
// Held at zero while clr_i is high so every run starts on a clean dwell.
module dwell_counter
  import pattern_checker_pkg::*;
#(
  parameter int unsigned DWELL     = DEF_DWELL,
  parameter int unsigned SAMPLE_AT = DWELL / 2,
  localparam int unsigned CW       = w_min1(DWELL)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  output logic [CW-1:0] cnt_o,
  output logic          sample_hit_o,
  output logic          last_o
);

  logic [CW-1:0] cnt_q, cnt_d;

  assign sample_hit_o = (cnt_q == CW'(SAMPLE_AT));
  assign last_o       = (cnt_q == CW'(DWELL - 1));
  assign cnt_o        = cnt_q;

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clr_i || last_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pattern_checker.sv
// Hardware verdict for a bit-pattern run: samples din mid-dwell,
// counts mismatches against PATTERN and reports pass with a done pulse.
module pattern_checker
  import pattern_checker_pkg::*;
#(
  parameter int unsigned         PAT_LEN   = DEF_PAT_LEN,
  parameter logic [PAT_LEN-1:0]  PATTERN   = 4'b0101,
  parameter int unsigned         DWELL     = DEF_DWELL,
  parameter int unsigned         SAMPLE_AT = DWELL / 2,
  parameter bit                  INVERT    = 1'b0,
  localparam int unsigned        EW        = $clog2(PAT_LEN + 1),
  localparam int unsigned        IW        = w_min1(PAT_LEN)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          din,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic          mismatch,
  output logic [EW-1:0] err_count,
  output logic [IW-1:0] bit_idx
);

  localparam int unsigned CW = w_min1(DWELL);

  state_e        state_q, state_d;
  logic [IW-1:0] bit_q, bit_d;
  logic [EW-1:0] err_q, err_d;
  logic          pass_q, pass_d;
  logic          done_q, done_d;
  logic          mis_q, mis_d;
  logic          busy_q, busy_d;

  logic [CW-1:0] cnt;
  logic          sample_hit;
  logic          last;
  logic          exp_bit;

  dwell_counter #(
    .DWELL     (DWELL),
    .SAMPLE_AT (SAMPLE_AT)
  ) u_dwell (
    .clk          (clk),
    .rst          (rst),
    .clr_i        (state_q != ST_RUN),
    .cnt_o        (cnt),
    .sample_hit_o (sample_hit),
    .last_o       (last)
  );

  assign exp_bit = PATTERN[bit_q] ^ INVERT;

  // pass uses err_d so the final comparison of the run is included
  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    err_d   = err_q;
    pass_d  = pass_q;
    done_d  = 1'b0;
    mis_d   = 1'b0;
    busy_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          bit_d   = '0;
          err_d   = '0;
          pass_d  = 1'b0;
          busy_d  = 1'b1;
        end
      end
      ST_RUN: begin
        busy_d = 1'b1;
        if (sample_hit && (din != exp_bit)) begin
          err_d = err_q + EW'(1);
          mis_d = 1'b1;
        end
        if (last) begin
          if (bit_q == IW'(PAT_LEN - 1)) begin
            state_d = ST_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_d == '0);
          end else begin
            bit_d = bit_q + IW'(1);
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      bit_q   <= '0;
      err_q   <= '0;
      pass_q  <= 1'b0;
      done_q  <= 1'b0;
      mis_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      err_q   <= err_d;
      pass_q  <= pass_d;
      done_q  <= done_d;
      mis_q   <= mis_d;
      busy_q  <= busy_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign mismatch  = mis_q;
  assign err_count = err_q;
  assign bit_idx   = bit_q;

endmodule

// File: tb/tb_pattern_checker.sv
// Scoreboard bench: runs push expected done/mismatch events, a monitor
// pops and compares them whenever a checker instance raises an output.
module tb_pattern_checker;

  localparam int D = 20;
  localparam int S = 10;
  localparam int P = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start [2];
  logic din   [2];
  logic busy  [2];
  logic done  [2];
  logic pass  [2];
  logic mism  [2];
  logic [2:0] errc [2];
  logic [1:0] bidx [2];

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int dut;
    int cyc;
    int pass;
    int err;
  } exp_done_t;

  typedef struct {
    int dut;
    int cyc;
  } exp_mis_t;

  exp_done_t dq[$];
  exp_mis_t  mq[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  pattern_checker u_norm (
    .clk       (clk),
    .rst       (rst),
    .start     (start[0]),
    .din       (din[0]),
    .busy      (busy[0]),
    .done      (done[0]),
    .pass      (pass[0]),
    .mismatch  (mism[0]),
    .err_count (errc[0]),
    .bit_idx   (bidx[0])
  );

  pattern_checker #(
    .PATTERN (4'b0101),
    .INVERT  (1'b1)
  ) u_inv (
    .clk       (clk),
    .rst       (rst),
    .start     (start[1]),
    .din       (din[1]),
    .busy      (busy[1]),
    .done      (done[1]),
    .pass      (pass[1]),
    .mismatch  (mism[1]),
    .err_count (errc[1]),
    .bit_idx   (bidx[1])
  );

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)",
               name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (done[d]) begin
        if (dq.size() == 0) begin
          chk($sformatf("dut%0d unexpected done", d), 1, 0);
        end else begin
          exp_done_t e;
          e = dq.pop_front();
          chk("done dut", d, e.dut);
          chk("done cycle", cyc, e.cyc);
          chk("done pass", int'(pass[d]), e.pass);
          chk("done err_count", int'(errc[d]), e.err);
          chk("done busy", int'(busy[d]), 0);
        end
      end
      if (mism[d]) begin
        if (mq.size() == 0) begin
          chk($sformatf("dut%0d unexpected mismatch", d), 1, 0);
        end else begin
          exp_mis_t m;
          m = mq.pop_front();
          chk("mismatch dut", d, m.dut);
          chk("mismatch cycle", cyc, m.cyc);
        end
      end
    end
  end

  // drv: din per bit (bit 0 first); mis: hand-computed mismatching bits
  task automatic do_run(input int d, input logic [3:0] drv,
                        input bit glitch, input int abort_off,
                        input bit mid_start, input logic [3:0] mis,
                        input int exp_err, input int post);
    int c0;
    int w;
    @(negedge clk);
    start[d] = 1'b1;
    @(posedge clk);
    #1;
    start[d] = 1'b0;
    c0 = cyc;
    chk("busy after start", int'(busy[d]), 1);
    chk("err cleared at start", int'(errc[d]), 0);
    for (int k = 0; k < P; k++) begin
      if (mis[k] && (abort_off < 0 || 1 + k * D + S <= abort_off)) begin
        mq.push_back('{dut: d, cyc: c0 + 1 + k * D + S});
      end
    end
    if (abort_off < 0) begin
      dq.push_back('{dut: d, cyc: c0 + P * D,
                     pass: (exp_err == 0) ? 1 : 0, err: exp_err});
    end
    for (int o = 0; o < P * D; o++) begin
      w = o % D;
      din[d] = drv[o / D] ^ (glitch && w >= 2 && w <= 4);
      start[d] = mid_start && (o == 24);
      if (o == abort_off) begin
        rst = 1'b1;
        start[d] = 1'b1;
      end
      @(posedge clk);
      #1;
      start[d] = 1'b0;
      if (rst) begin
        rst = 1'b0;
        chk("abort busy", int'(busy[d]), 0);
        chk("abort err_count", int'(errc[d]), 0);
        chk("abort done", int'(done[d]), 0);
        chk("abort pass", int'(pass[d]), 0);
        repeat (3) @(posedge clk);
        return;
      end
    end
    repeat (post) @(posedge clk);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      start[d] = 1'b0;
      din[d]   = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("reset busy", int'(busy[d]), 0);
      chk("reset done", int'(done[d]), 0);
      chk("reset pass", int'(pass[d]), 0);
      chk("reset mismatch", int'(mism[d]), 0);
      chk("reset err_count", int'(errc[d]), 0);
      chk("reset bit_idx", int'(bidx[d]), 0);
    end
    rst = 1'b0;

    do_run(0, 4'b0101, 0, -1, 0, 4'b0000, 0, 3);
    do_run(0, 4'b0001, 0, -1, 0, 4'b0100, 1, 3);
    do_run(0, 4'b0000, 0, -1, 0, 4'b0101, 2, 3);
    do_run(0, 4'b0101, 1, -1, 0, 4'b0000, 0, 3);
    do_run(0, 4'b0101, 0, -1, 1, 4'b0000, 0, 3);
    do_run(0, 4'b0101, 0, 34, 0, 4'b0000, 0, 3);
    do_run(0, 4'b0101, 0, -1, 0, 4'b0000, 0, 1);
    do_run(0, 4'b1111, 0, -1, 0, 4'b1010, 2, 3);
    do_run(1, 4'b1010, 0, -1, 0, 4'b0000, 0, 3);
    do_run(1, 4'b0101, 0, -1, 0, 4'b1111, 4, 3);

    repeat (5) @(posedge clk);
    chk("pending done events", dq.size(), 0);
    chk("pending mismatch events", mq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
